dac_interpolator: RTL and testbench

Output-path companion to the ADC-side moving-average filter in the FOG loop. Accepts low-rate signed 32-bit control samples over a valid/ready handshake and produces one 14-bit signed DAC word every clock. Between updates it linearly ramps from the previous target to the new one over `INTERP_NUM` clocks, with saturation to DAC range. Sits between the loop-filter / ramp-generator output and the DAC driver.

---
 rtl/dac_interpolator.sv | 92 +++++++++
 tb/tb_dac_interpolator.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_interpolator.sv
// Linear-ramp DAC interpolator: 32-bit targets in, one saturated 14-bit word per clock; first dout change 2 clocks after accept, final value after N+1.
// Backpressure: din_ready drops during a ramp and reopens on its last step, so back-to-back ramps run without a gap.
module dac_interpolator #(
  parameter int INTERP_NUM = 8,
  parameter int INTERP_BIT = 3
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic signed [31:0] din,
  input  logic               din_valid,
  output logic               din_ready,
  output logic signed [13:0] dout,
  output logic               busy,
  output logic               sat
);

  localparam int ACC_W = 34 + INTERP_BIT;

  localparam logic HOLD = 1'b0;
  localparam logic RAMP = 1'b1;

  localparam logic [INTERP_BIT-1:0]    CNT_LAST = INTERP_BIT'(INTERP_NUM - 1);
  localparam logic signed [ACC_W-1:0] POS_LIM  = ACC_W'(8191);
  localparam logic signed [ACC_W-1:0] NEG_LIM  = ACC_W'(-8192);

  logic                    state;
  logic signed [31:0]      tgt;
  logic signed [32:0]      step;
  logic signed [ACC_W-1:0] acc;
  logic [INTERP_BIT-1:0]   cnt;

  logic                    last_step;
  logic                    accept;
  logic signed [32:0]      step_nxt;
  logic signed [ACC_W-1:0] acc_nxt;
  logic signed [ACC_W-1:0] acc_shr;
  logic signed [13:0]      dout_nxt;
  logic                    sat_nxt;

  assign last_step = (state == RAMP) && (cnt == CNT_LAST);
  assign din_ready = (state == HOLD) || last_step;
  assign accept    = din_valid && din_ready;
  assign busy      = (state == RAMP);

  // 33-bit difference of two 32-bit signed values cannot overflow.
  assign step_nxt = {din[31], din} - {tgt[31], tgt};
  assign acc_nxt  = acc + {{(ACC_W-33){step[32]}}, step};
  assign acc_shr  = acc >>> INTERP_BIT;

  always_comb begin
    sat_nxt  = 1'b0;
    dout_nxt = acc_shr[13:0];
    if (acc_shr > POS_LIM) begin
      dout_nxt = 14'sh1FFF;
      sat_nxt  = 1'b1;
    end else if (acc_shr < NEG_LIM) begin
      dout_nxt = 14'sh2000;
      sat_nxt  = 1'b1;
    end
  end

  // An accept on the final ramp edge overrides the HOLD transition and
  // the counter increment, while the old step's last add still lands.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= HOLD;
      tgt   <= '0;
      step  <= '0;
      acc   <= '0;
      cnt   <= '0;
      dout  <= '0;
      sat   <= 1'b0;
    end else begin
      dout <= dout_nxt;
      sat  <= sat_nxt;
      if (state == RAMP) begin
        acc <= acc_nxt;
        cnt <= cnt + 1'b1;
        if (cnt == CNT_LAST) begin
          state <= HOLD;
        end
      end
      if (accept) begin
        step  <= step_nxt;
        tgt   <= din;
        cnt   <= '0;
        state <= RAMP;
      end
    end
  end

endmodule

// File: tb/tb_dac_interpolator.sv
// Bench for dac_interpolator: an arithmetic ramp model checked every cycle, plus directed ramps with literal expectations.
module tb_dac_interpolator;

  localparam int N  = 8;
  localparam int IB = 3;

  logic               i_clk = 1'b0;
  logic               i_rst_n = 1'b1;
  logic signed [31:0] din = '0;
  logic               din_valid = 1'b0;
  logic               din_ready;
  logic signed [13:0] dout;
  logic               busy;
  logic               sat;

  dac_interpolator #(.INTERP_NUM(N), .INTERP_BIT(IB)) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .dout      (dout),
    .busy      (busy),
    .sat       (sat)
  );

  always #5 i_clk = ~i_clk;

  int     checks = 0;
  int     failures = 0;
  longint edges = 0;
  bit     chk_en = 1'b0;

  // Model: each accepted sample defines a ramp whose i-th output is
  // floor((prev*N + i*(new-prev)) / N), clamped to the 14-bit range.
  int     exp_d[longint];
  bit     exp_s[longint];
  bit     exp_b[longint];
  bit     exp_r[longint];
  longint m_tgt = 0;
  int     last_d = 0;
  bit     last_s = 1'b0;

  int     rec_d[0:31];
  bit     rec_s[0:31];
  bit     rec_b[0:31];

  function automatic longint fdiv(input longint v, input longint d);
    longint q;
    q = v / d;
    if ((v % d) != 0 && v < 0) q = q - 1;
    return q;
  endfunction

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, req, $time);
    end
  endtask

  bit     mdl_busy, mdl_rdy;
  longint mdl_prev, mdl_step, mdl_q, mdl_k;

  always @(posedge i_clk) begin
    mdl_busy = exp_b.exists(edges);
    mdl_rdy  = !mdl_busy || exp_r.exists(edges);
    if (i_rst_n && din_valid && mdl_rdy) begin
      mdl_k    = edges + 1;
      mdl_prev = m_tgt;
      mdl_step = longint'(din) - mdl_prev;
      for (int i = 1; i <= N; i++) begin
        mdl_q = fdiv(mdl_prev * N + i * mdl_step, N);
        if (mdl_q > 8191) begin
          exp_d[mdl_k+1+i] = 8191;
          exp_s[mdl_k+1+i] = 1'b1;
        end else if (mdl_q < -8192) begin
          exp_d[mdl_k+1+i] = -8192;
          exp_s[mdl_k+1+i] = 1'b1;
        end else begin
          exp_d[mdl_k+1+i] = int'(mdl_q);
          exp_s[mdl_k+1+i] = 1'b0;
        end
      end
      for (int j = 0; j < N; j++) exp_b[mdl_k+j] = 1'b1;
      exp_r[mdl_k+N-1] = 1'b1;
      m_tgt = longint'(din);
    end
    edges++;
  end

  always @(negedge i_rst_n) begin
    exp_d.delete();
    exp_s.delete();
    exp_b.delete();
    exp_r.delete();
    m_tgt  = 0;
    last_d = 0;
    last_s = 1'b0;
  end

  bit cmp_busy, cmp_rdy;

  always @(negedge i_clk) begin
    if (chk_en) begin
      if (exp_d.exists(edges)) begin
        last_d = exp_d[edges];
        last_s = exp_s[edges];
      end
      cmp_busy = exp_b.exists(edges);
      cmp_rdy  = !cmp_busy || exp_r.exists(edges);
      chk("model_dout", longint'(dout), last_d);
      chk("model_sat", longint'(sat), longint'(last_s));
      chk("model_busy", longint'(busy), longint'(cmp_busy));
      chk("model_din_ready", longint'(din_ready), longint'(cmp_rdy));
    end
  end

  // Leaves the bench at the negedge after the accepting edge, valid dropped.
  task automatic do_accept(input int v);
    bit done;
    done = 1'b0;
    @(negedge i_clk);
    din       = v;
    din_valid = 1'b1;
    for (int t = 0; t < 50 && !done; t++) begin
      if (din_ready) begin
        @(posedge i_clk);
        done = 1'b1;
      end else begin
        @(negedge i_clk);
      end
    end
    if (!done) chk("accept_timeout", 0, 1);
    @(negedge i_clk);
    din_valid = 1'b0;
    rec_d[0] = int'(dout);
    rec_s[0] = sat;
    rec_b[0] = busy;
  endtask

  task automatic capture(input int n);
    for (int j = 1; j <= n; j++) begin
      @(negedge i_clk);
      rec_d[j] = int'(dout);
      rec_s[j] = sat;
      rec_b[j] = busy;
    end
  endtask

  int busy_cnt;
  int exp5[8];
  int expm3[8];

  initial begin
    exp5  = '{0, 1, 1, 2, 3, 3, 4, 5};
    expm3 = '{4, 3, 2, 1, 0, -1, -2, -3};

    #2 i_rst_n = 1'b0;
    #20;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    chk_en  = 1'b1;

    repeat (20) @(negedge i_clk);
    chk("idle_dout", longint'(dout), 0);
    chk("idle_sat", longint'(sat), 0);
    chk("idle_busy", longint'(busy), 0);
    chk("idle_ready", longint'(din_ready), 1);

    // Single 800 ramp from 0.
    do_accept(800);
    capture(12);
    busy_cnt = 0;
    for (int j = 0; j <= 12; j++) busy_cnt += int'(rec_b[j]);
    chk("ramp800_busy_cycles", busy_cnt, 8);
    chk("ramp800_pre", rec_d[1], 0);
    for (int j = 2; j <= 9; j++) chk("ramp800_step", rec_d[j], 100 * (j - 1));
    chk("ramp800_hold", rec_d[12], 800);

    do_accept(0);
    capture(10);
    chk("ramp_to0_end", rec_d[9], 0);

    // Back-to-back 800 then 0, with an ignored pulse at cnt=3.
    do_accept(800);
    for (int j = 1; j <= 18; j++) begin
      @(negedge i_clk);
      rec_d[j] = int'(dout);
      rec_b[j] = busy;
      if (j == 3) begin
        chk("ready_low_mid_ramp", longint'(din_ready), 0);
        din       = 12345;
        din_valid = 1'b1;
      end
      if (j == 4) din_valid = 1'b0;
      if (j == 7) begin
        din       = 0;
        din_valid = 1'b1;
      end
      if (j == 8) din_valid = 1'b0;
    end
    for (int j = 2; j <= 17; j++)
      chk("b2b_seq", rec_d[j], (j <= 9) ? 100 * (j - 1) : 800 - 100 * (j - 9));
    chk("b2b_busy_no_gap", longint'(rec_b[8]), 1);
    chk("b2b_busy_end", longint'(rec_b[16]), 0);

    // Fractional steps: 0 -> 5 -> -3.
    do_accept(5);
    capture(10);
    for (int j = 2; j <= 9; j++) chk("ramp5_seq", rec_d[j], exp5[j-2]);
    do_accept(-3);
    capture(10);
    for (int j = 2; j <= 9; j++) chk("rampm3_seq", rec_d[j], expm3[j-2]);

    // Saturation both ways.
    do_accept(0);
    capture(10);
    do_accept(20000);
    capture(10);
    chk("sat_up_1", rec_d[2], 2500);
    chk("sat_up_2", rec_d[3], 5000);
    chk("sat_up_3", rec_d[4], 7500);
    chk("sat_up_3_flag", longint'(rec_s[4]), 0);
    chk("sat_up_4", rec_d[5], 8191);
    chk("sat_up_4_flag", longint'(rec_s[5]), 1);
    chk("sat_up_end_flag", longint'(rec_s[9]), 1);
    do_accept(-20000);
    capture(10);
    chk("sat_dn_mid", rec_d[4], 5000);
    chk("sat_dn_mid_flag", longint'(rec_s[4]), 0);
    chk("sat_dn_end", rec_d[9], -8192);
    chk("sat_dn_end_flag", longint'(rec_s[9]), 1);

    // Asynchronous reset at cnt=4, then a fresh ramp from 0.
    do_accept(800);
    repeat (4) @(negedge i_clk);
    #1 i_rst_n = 1'b0;
    #1;
    chk("rst_dout", longint'(dout), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_ready", longint'(din_ready), 1);
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    do_accept(80);
    capture(10);
    for (int j = 2; j <= 9; j++) chk("ramp80_seq", rec_d[j], 10 * (j - 1));

    repeat (3) @(negedge i_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
